bk_ce_gen: RTL and testbench
============================

# bk_ce_gen

Parametrised multi-channel clock-enable generator for the BK0010/BK0011M core. It replaces the fixed CPU/PSG/pixel dividers with NCH independent channels, each producing a positive-phase and a negative-phase single-cycle enable from `clk_sys`. Each channel has a runtime divisor and a runtime phase offset. New divisor/phase values take effect only at a period boundary, and only while the channel's `hold` input is low, so a speed (turbo) change never lands mid bus cycle. The block sits beside the PLL and feeds `ce_cpu_p`/`ce_cpu_n`, `ce_psg`, video enables and similar.

## Interface
- NCH, 4, number of independent channels
- DIVW, 6, width of the per-channel divisor and phase fields
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- div_i  in  NCH*DIVW  per-channel period minus 1 (channel i at [i*DIVW +: DIVW])
- phase_i  in  NCH*DIVW  per-channel counter value at which ce_n fires
- run  in  NCH  channel enable; low = counter parked at 0, outputs 0
- hold  in  NCH  defer divisor/phase reload while high (e.g. bus_sync)
- resync  in  1  single-cycle pulse: zero all running counters together
- ce_p  out  NCH  positive-phase enable, one clk_sys wide
- ce_n  out  NCH  negative-phase enable, one clk_sys wide
- pend  out  NCH  new div_i/phase_i presented but not yet loaded

## Operation
- Per-channel state: cnt[DIVW], act_div[DIVW], act_ph[DIVW].
- Mismatch condition: mis = (div_i != act_div) | (phase_i != act_ph).
- Reset:
  - cnt=0, act_div=div_i, act_ph=phase_i.
  - ce_p=0, ce_n=0, pend=0.
- Per-cycle priority: reset > run low > resync > normal count.
- run low:
  - cnt<=0; ce_p, ce_n <= 0.
  - act_div/act_ph load div_i/phase_i immediately, regardless of hold.
- Normal (run high):
  - ce_p <= (cnt==0).
  - ce_n <= (cnt==act_ph).
  - If cnt==act_div: cnt<=0, and if !hold also act_div<=div_i, act_ph<=phase_i.
  - Otherwise cnt<=cnt+1.
- resync (run high): cnt<=0 for every running channel. ce_p/ce_n are still computed from the pre-resync cnt. No reload occurs on resync unless cnt==act_div that same cycle.
- pend <= run & mis evaluated after the update. It is a registered status, not an event.
- Boundary cases:
  - act_div=0: ce_p every cycle.
  - act_ph==0: ce_n coincides with ce_p.
  - act_ph>act_div: ce_n never asserts.
  - cnt saturation cannot occur because reload happens at act_div.
  - div_i changing while hold stays high: old period continues indefinitely; pend stays 1.
  - hold dropping mid-period: load happens at the next wrap, not immediately.
- Unsigned arithmetic only. cnt compares are DIVW-bit exact; no truncation.

## Timing
- All outputs registered. Output latency is 1 cycle from the cnt value that produced the enable.
- Period of ce_p = act_div+1 cycles. ce_n follows ce_p by act_ph cycles.
- run rising in cycle k (cnt=0): first ce_p at k+1, next at k+1+(act_div+1).
- New divisor:
  - Loaded on the wrap edge where hold is low.
  - The first cycle of the new period is the cycle of the next ce_p.
  - Each period is therefore entirely old or entirely new.
- reset mid-period:
  - ce_p/ce_n low in the following cycle.
  - The first ce_p appears one cycle after reset is released, if run is high.

## Test plan
- Reset release with NCH=2, ch0 div=3/phase=2, run=11 -> ch0 ce_p at cycles 1,5,9…; ce_n at 3,7,11…; all outputs 0 during reset.
- Turbo switch: ch0 div 23→11 while hold=1 for 40 cycles -> period stays 24, pend=1 throughout. Hold drops at cnt=5 -> remaining periods 24 until wrap, then 12; pend clears the cycle after load.
- Degenerate values: div=0/phase=0 -> ce_p=ce_n=1 every cycle. div=4/phase=7 -> ce_p period 5, ce_n never asserts.
- Run gating: drop run mid-period with div_i changed -> outputs 0 next cycle, act_div updated despite hold=1. Raise run -> ce_p exactly 1 cycle later.
- Resync: channels div=7 and div=5 running out of phase, pulse resync -> both ce_p coincide 1 cycle after the resync edge, then at their own periods.
- Random regression, 10k cycles with random div/phase/hold/run, against a cycle model -> zero mismatches. ce_p/ce_n are never wider than one cycle unless div=0.

Source files
------------

// File: rtl/bk_ce_gen.sv
// -----------------------------------------------------------------------------
// bk_ce_gen
//
// Multi-channel clock-enable generator for the BK0010/BK0011M core. Each of
// NCH channels divides clk_sys by a runtime divisor and emits two one-cycle
// enables per period:
//   ce_p : fires on the cycle after the counter sits at 0 (period start)
//   ce_n : fires on the cycle after the counter sits at the phase value
// A new divisor/phase is only adopted on the wrap edge of the current period,
// and only if that channel's hold input is low. Every period is therefore
// either entirely old or entirely new, so a turbo switch never splits a bus
// cycle.
//
// Ports
//   clk_sys  in   system clock, all logic on the rising edge
//   reset    in   synchronous, active-high reset
//   div_i    in   NCH*DIVW  per-channel period minus 1, channel i at [i*DIVW +: DIVW]
//   phase_i  in   NCH*DIVW  per-channel counter value at which ce_n fires
//   run      in   NCH       channel enable; low parks the counter at 0
//   hold     in   NCH       defer divisor/phase reload while high
//   resync   in   1         one-cycle pulse: restart all running counters at 0
//   ce_p     out  NCH       positive-phase enable, one clk_sys wide
//   ce_n     out  NCH       negative-phase enable, one clk_sys wide
//   pend     out  NCH       presented div_i/phase_i not yet adopted
// -----------------------------------------------------------------------------
module bk_ce_gen #(
  parameter int NCH  = 4,
  parameter int DIVW = 6
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [NCH*DIVW-1:0] div_i,
  input  logic [NCH*DIVW-1:0] phase_i,
  input  logic [NCH-1:0]      run,
  input  logic [NCH-1:0]      hold,
  input  logic                resync,
  output logic [NCH-1:0]      ce_p,
  output logic [NCH-1:0]      ce_n,
  output logic [NCH-1:0]      pend
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch

    // Presented (requested) settings for this channel.
    logic [DIVW-1:0] div_w;
    logic [DIVW-1:0] ph_w;

    // Active state: position in the period and the settings in force.
    logic [DIVW-1:0] cnt_q;
    logic [DIVW-1:0] act_div_q;
    logic [DIVW-1:0] act_ph_q;

    // Next-state values.
    logic [DIVW-1:0] cnt_d;
    logic [DIVW-1:0] act_div_d;
    logic [DIVW-1:0] act_ph_d;

    logic            wrap;
    logic            load;

    logic            ce_p_q;
    logic            ce_n_q;
    logic            pend_q;

    assign div_w = div_i[g*DIVW +: DIVW];
    assign ph_w  = phase_i[g*DIVW +: DIVW];

    always_comb begin
      wrap      = (cnt_q == act_div_q);
      // A parked channel tracks its inputs continuously; a running channel
      // only adopts them on the wrap edge, and only when not held off.
      load      = !run[g] || (wrap && !hold[g]);
      act_div_d = act_div_q;
      act_ph_d  = act_ph_q;
      if (load) begin
        act_div_d = div_w;
        act_ph_d  = ph_w;
      end

      cnt_d = cnt_q + DIVW'(1);
      if (!run[g] || wrap || resync) begin
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        cnt_q     <= '0;
        act_div_q <= div_w;
        act_ph_q  <= ph_w;
        ce_p_q    <= 1'b0;
        ce_n_q    <= 1'b0;
        pend_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        act_div_q <= act_div_d;
        act_ph_q  <= act_ph_d;
        // Enables come from the counter value before this edge's update,
        // so a resync pulse does not suppress or add an enable this cycle.
        ce_p_q    <= run[g] && (cnt_q == '0);
        ce_n_q    <= run[g] && (cnt_q == act_ph_q);
        // Status reflects the settings that are in force after this edge.
        pend_q    <= run[g] && ((div_w != act_div_d) || (ph_w != act_ph_d));
      end
    end

    assign ce_p[g] = ce_p_q;
    assign ce_n[g] = ce_n_q;
    assign pend[g] = pend_q;

  end : g_ch

endmodule

// File: tb/tb_bk_ce_gen.sv
// -----------------------------------------------------------------------------
// tb_bk_ce_gen
//
// Bench for bk_ce_gen. Directed scenarios followed by a randomized run. A
// reference model describes each channel by its position inside the current
// period, the period length in cycles and the ce_n offset; it predicts the
// registered outputs for every cycle and is compared on all three vectors.
// -----------------------------------------------------------------------------
module tb_bk_ce_gen;

  localparam int NCH  = 4;
  localparam int DIVW = 6;

  // Clock / reset
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic                reset;
  logic [NCH*DIVW-1:0] div_i;
  logic [NCH*DIVW-1:0] phase_i;
  logic [NCH-1:0]      run;
  logic [NCH-1:0]      hold;
  logic                resync;
  logic [NCH-1:0]      ce_p;
  logic [NCH-1:0]      ce_n;
  logic [NCH-1:0]      pend;

  // Driven settings, one entry per channel.
  int unsigned d_div [NCH];
  int unsigned d_ph  [NCH];

  always_comb begin
    div_i   = '0;
    phase_i = '0;
    for (int c = 0; c < NCH; c++) begin
      div_i[c*DIVW +: DIVW]   = DIVW'(d_div[c]);
      phase_i[c*DIVW +: DIVW] = DIVW'(d_ph[c]);
    end
  end

  bk_ce_gen #(.NCH(NCH), .DIVW(DIVW)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .div_i   (div_i),
    .phase_i (phase_i),
    .run     (run),
    .hold    (hold),
    .resync  (resync),
    .ce_p    (ce_p),
    .ce_n    (ce_n),
    .pend    (pend)
  );

  // Reference model: pos = cycles elapsed in the current period,
  // per = period length in cycles, off = ce_n offset.
  int          m_pos [NCH];
  int          m_per [NCH];
  int          m_off [NCH];
  logic [NCH-1:0] e_p;
  logic [NCH-1:0] e_n;
  logic [NCH-1:0] e_pend;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      if (reset || !run[c]) begin
        m_pos[c] = 0;
        m_per[c] = int'(d_div[c]) + 1;
        m_off[c] = int'(d_ph[c]);
        e_p[c]   = 1'b0;
        e_n[c]   = 1'b0;
        e_pend[c] = 1'b0;
      end else begin
        e_p[c] = (m_pos[c] == 0);
        e_n[c] = (m_pos[c] == m_off[c]);
        if (m_pos[c] == m_per[c] - 1) begin
          m_pos[c] = 0;
          if (!hold[c]) begin
            m_per[c] = int'(d_div[c]) + 1;
            m_off[c] = int'(d_ph[c]);
          end
        end else if (resync) begin
          m_pos[c] = 0;
        end else begin
          m_pos[c] = m_pos[c] + 1;
        end
        e_pend[c] = (m_per[c] != int'(d_div[c]) + 1) || (m_off[c] != int'(d_ph[c]));
      end
    end
  endtask

  task automatic check_model();
    vectors++;
    assert (ce_p === e_p) else begin
      miscompares++;
      $error("FAIL ce_p cyc=%0d observed=%b expected=%b", cyc, ce_p, e_p);
    end
    vectors++;
    assert (ce_n === e_n) else begin
      miscompares++;
      $error("FAIL ce_n cyc=%0d observed=%b expected=%b", cyc, ce_n, e_n);
    end
    vectors++;
    assert (pend === e_pend) else begin
      miscompares++;
      $error("FAIL pend cyc=%0d observed=%b expected=%b", cyc, pend, e_pend);
    end
  endtask

  // One clock: model advances on the edge, outputs are compared 1 time unit
  // later; inputs are only changed by the caller after that point.
  task automatic tick();
    @(posedge clk_sys);
    model_step();
    cyc++;
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Waits for a ce_p on channel ch, then counts cycles to the next one.
  task automatic measure_gap(input int ch, input int expv, input string tag);
    int n;
    int gap;
    n = 0;
    while (ce_p[ch] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    gap = 0;
    do begin
      tick();
      gap++;
    end while (ce_p[ch] !== 1'b1 && gap < 200);
    vectors++;
    assert (gap == expv) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed gap=%0d expected gap=%0d", tag, cyc, gap, expv);
    end
  endtask

  initial begin
    int n;

    // Reset with ch0 div=3/ph=2, ch1 div=5/ph=1, ch2 div=0/ph=0, ch3 div=4/ph=7
    reset  = 1'b1;
    resync = 1'b0;
    run    = 4'b1111;
    hold   = 4'b0000;
    d_div[0] = 3; d_ph[0] = 2;
    d_div[1] = 5; d_ph[1] = 1;
    d_div[2] = 0; d_ph[2] = 0;
    d_div[3] = 4; d_ph[3] = 7;
    for (int c = 0; c < NCH; c++) m_pos[c] = 0;
    ticks(3);
    expect_bit("reset_ce_p_zero", |ce_p, 1'b0);
    expect_bit("reset_ce_n_zero", |ce_n, 1'b0);
    expect_bit("reset_pend_zero", |pend, 1'b0);

    // Reset release: first ce_p one cycle later; ce_n two cycles after that.
    reset = 1'b0;
    tick();
    expect_bit("rel_ch0_ce_p_c1", ce_p[0], 1'b1);
    expect_bit("rel_ch0_ce_n_c1", ce_n[0], 1'b0);
    tick();
    tick();
    expect_bit("rel_ch0_ce_n_c3", ce_n[0], 1'b1);
    tick();
    tick();
    expect_bit("rel_ch0_ce_p_c5", ce_p[0], 1'b1);

    // Degenerate channels: div=0/ph=0 fires both every cycle, ph>div never.
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_bit("deg_ch2_ce_p", ce_p[2], 1'b1);
      expect_bit("deg_ch2_ce_n", ce_n[2], 1'b1);
      expect_bit("deg_ch3_ce_n", ce_n[3], 1'b0);
    end
    measure_gap(3, 5, "deg_ch3_period");

    // Turbo switch: adopt div=23, then request 11 while held.
    d_div[0] = 23; d_ph[0] = 3;
    ticks(10);
    hold[0] = 1'b1;
    d_div[0] = 11;
    ticks(40);
    expect_bit("turbo_pend_held", pend[0], 1'b1);
    measure_gap(0, 24, "turbo_old_period");
    expect_bit("turbo_pend_still", pend[0], 1'b1);
    n = 0;
    while (m_pos[0] != 5 && n < 100) begin
      tick();
      n++;
    end
    expect_bit("turbo_reach_cnt5", (m_pos[0] == 5), 1'b1);
    hold[0] = 1'b0;
    measure_gap(0, 12, "turbo_new_period");
    expect_bit("turbo_pend_clear", pend[0], 1'b0);

    // Run gating on ch1 with a new divisor presented under hold.
    hold[1]  = 1'b1;
    d_div[1] = 9;
    ticks(3);
    run[1] = 1'b0;
    tick();
    expect_bit("gate_ce_p_off", ce_p[1], 1'b0);
    expect_bit("gate_ce_n_off", ce_n[1], 1'b0);
    expect_bit("gate_pend_off", pend[1], 1'b0);
    ticks(2);
    run[1] = 1'b1;
    tick();
    expect_bit("gate_first_ce_p", ce_p[1], 1'b1);
    measure_gap(1, 10, "gate_new_period");

    // Resync: ch0 div=7, ch1 div=5 drift apart, then restart together.
    hold[1]  = 1'b0;
    d_div[0] = 7; d_ph[0] = 2;
    d_div[1] = 5; d_ph[1] = 3;
    ticks(41);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    tick();
    expect_bit("resync_ch0_ce_p", ce_p[0], 1'b1);
    expect_bit("resync_ch1_ce_p", ce_p[1], 1'b1);
    measure_gap(1, 6, "resync_ch1_period");

    // Randomized regression.
    for (int i = 0; i < 10000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 99) < 3) begin
          d_div[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
          d_ph[c]  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 8);
        end
        if ($urandom_range(0, 99) < 10) hold[c] = ~hold[c];
        if ($urandom_range(0, 99) < 2)  run[c]  = ~run[c];
      end
      resync = ($urandom_range(0, 99) == 0);
      reset  = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset  = 1'b0;
    resync = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
